// File: rtl/gray_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : gray_ctrl_pkg
// Purpose: Shared types, limits and conversion helpers for the shared
//          binary/Gray conversion scheduler.
// Contents:
//   state_e        output-register FSM state {EMPTY, FULL}
//   RR_MAX_NREQ    largest supported requester count
//   CONV_MAX_W     largest supported code word width
//   bin2gray()     width-generic binary->Gray (zero-extended operand)
//   gray2bin()     width-generic Gray->binary (zero-extended operand)
// Revision: 1.0 - initial release
// ============================================================================
package gray_ctrl_pkg;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  localparam int RR_MAX_NREQ = 16;
  localparam int CONV_MAX_W  = 64;

  // Zero-extension above the real MSB makes the top bit pass straight
  // through, so one wide function serves every WIDTH up to CONV_MAX_W.
  function automatic logic [CONV_MAX_W-1:0] bin2gray(input logic [CONV_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down; zero-extended upper bits contribute nothing.
  function automatic logic [CONV_MAX_W-1:0] gray2bin(input logic [CONV_MAX_W-1:0] g);
    logic [CONV_MAX_W-1:0] b;
    b[CONV_MAX_W-1] = g[CONV_MAX_W-1];
    for (int i = CONV_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage : gray_ctrl_pkg
`default_nettype wire

// File: rtl/gray_conv_core.sv
`default_nettype none
// ============================================================================
// Module : gray_conv_core
// Purpose: Combinational WIDTH-bit code converter.
// Macro  : GRAY_DECODE_EN - adds dir_i (0 = binary->Gray, 1 = Gray->binary)
// Ports  :
//   data_i  in   WIDTH  word to convert
//   dir_i   in   1      conversion direction (GRAY_DECODE_EN only)
//   data_o  out  WIDTH  converted word
// Revision: 1.0 - initial release
// ============================================================================
module gray_conv_core
  import gray_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] data_i,
`ifdef GRAY_DECODE_EN
  input  logic             dir_i,
`endif
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] enc;

  assign enc = WIDTH'(bin2gray(CONV_MAX_W'(data_i)));

`ifdef GRAY_DECODE_EN
  logic [WIDTH-1:0] dec;
  assign dec    = WIDTH'(gray2bin(CONV_MAX_W'(data_i)));
  assign data_o = dir_i ? dec : enc;
`else
  assign data_o = enc;
`endif

endmodule : gray_conv_core
`default_nettype wire

// File: rtl/gray_conv_scheduler.sv
`default_nettype none
// ============================================================================
// Module : gray_conv_scheduler
// Purpose: Round-robin arbiter sharing one code converter among NREQ
//          requesters; results are held in one output register that drains
//          through a valid/ready handshake.
// Macro  : GRAY_DECODE_EN - adds req_dir / out_dir (Gray->binary option)
// Ports  :
//   clk        in   1           rising-edge clock
//   rst        in   1           asynchronous active-high reset
//   req_valid  in   NREQ        requester i presents a word
//   req_data   in   NREQ*WIDTH  word of requester i at [i*WIDTH +: WIDTH]
//   req_dir    in   NREQ        per-requester direction (GRAY_DECODE_EN)
//   req_ready  out  NREQ        one-hot grant, combinational
//   out_valid  out  1           output register holds a word
//   out_ready  in   1           consumer takes the word
//   out_data   out  WIDTH       converted word
//   out_id     out  IDW         index of the producing requester
//   out_dir    out  1           direction of the held word (GRAY_DECODE_EN)
//   busy       out  1           FSM in FULL
// Revision: 1.0 - initial release
// ============================================================================
module gray_conv_scheduler
  import gray_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
`ifdef GRAY_DECODE_EN
  input  logic [NREQ-1:0]       req_dir,
  output logic                  out_dir,
`endif
  output logic [NREQ-1:0]       req_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [IDW-1:0]        out_id,
  output logic                  busy
);

  state_e           state_q;
  logic [IDW-1:0]   rr_ptr_q;
  logic [IDW-1:0]   rr_ptr_d;
  logic [WIDTH-1:0] out_data_q;
  logic [IDW-1:0]   out_id_q;

  logic             slot;
  logic             found;
  logic [IDW-1:0]   gnt_idx;
  logic             load;
  logic [WIDTH-1:0] sel_data;
  logic [WIDTH-1:0] conv_data;

  // A grant slot exists when the register is free now or drains this cycle.
  assign slot = (state_q == EMPTY) || out_ready;

  // First valid requester at or after rr_ptr, searching modulo NREQ.
  always_comb begin
    int idx;
    found   = 1'b0;
    gnt_idx = '0;
    for (int off = 0; off < NREQ; off++) begin
      idx = int'(rr_ptr_q) + off;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_valid[idx]) begin
        found   = 1'b1;
        gnt_idx = IDW'(idx);
      end
    end
  end

  assign rr_ptr_d = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + IDW'(1);
  assign load     = slot && found;

  // rst gates the grant so no requester sees an accept while the block is
  // being cleared.
  always_comb begin
    req_ready = '0;
    if (load && !rst) req_ready[gnt_idx] = 1'b1;
  end

  assign sel_data = req_data[gnt_idx*WIDTH +: WIDTH];

  gray_conv_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .data_i (sel_data),
`ifdef GRAY_DECODE_EN
    .dir_i  (req_dir[gnt_idx]),
`endif
    .data_o (conv_data)
  );

`ifdef GRAY_DECODE_EN
  logic out_dir_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       out_dir_q <= 1'b0;
    else if (load) out_dir_q <= req_dir[gnt_idx];
  end
  assign out_dir = out_dir_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      rr_ptr_q   <= '0;
      out_data_q <= '0;
      out_id_q   <= '0;
    end else begin
      if (load) begin
        state_q    <= FULL;
        rr_ptr_q   <= rr_ptr_d;
        out_data_q <= conv_data;
        out_id_q   <= gnt_idx;
      end else if (state_q == FULL && out_ready) begin
        state_q <= EMPTY;
      end
    end
  end

  assign out_valid = (state_q == FULL);
  assign busy      = (state_q == FULL);
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;

endmodule : gray_conv_scheduler
`default_nettype wire

// File: tb/tb_gray_conv_scheduler.sv
`default_nettype none
// ============================================================================
// Module : tb_gray_conv_scheduler
// Purpose: Directed self-checking bench for gray_conv_scheduler (WIDTH=4,
//          NREQ=4). GRAY_DECODE_EN steps run only when the macro is defined.
// Revision: 1.0 - initial release
// ============================================================================
module tb_gray_conv_scheduler;

  localparam int WIDTH = 4;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_data;
  logic [IDW-1:0]    out_id;
  logic              busy;
`ifdef GRAY_DECODE_EN
  logic [NREQ-1:0]   req_dir;
  logic              out_dir;
`endif

  int errors = 0;
  int checks = 0;

  gray_conv_scheduler #(
    .WIDTH (WIDTH),
    .NREQ  (NREQ)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
`ifdef GRAY_DECODE_EN
    .req_dir   (req_dir),
    .out_dir   (out_dir),
`endif
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Grant order, results and tags for four continuously valid requesters
  // holding 1000, 0101, 1111, 0000 starting from rr_ptr = 0.
  logic [3:0] rr_gnt  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [3:0] rr_data [5] = '{4'b1100, 4'b0111, 4'b1000, 4'b0000, 4'b1100};
  logic [1:0] rr_id   [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    out_ready = 1'b0;
`ifdef GRAY_DECODE_EN
    req_dir   = '0;
`endif
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_out_id",    32'(out_id),    32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    req_valid = 4'b0001;
    #1;
    chk("rst_no_grant",  32'(req_ready), 32'd0);

    // Single request from requester 0: 1011 -> 1110
    tick();
    rst       = 1'b0;
    req_data  = 16'h000B;
    out_ready = 1'b1;
    #1;
    chk("single_gnt", 32'(req_ready), 32'b0001);
    tick();
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_data",  32'(out_data),  32'b1110);
    chk("single_id",    32'(out_id),    32'd0);
    chk("single_busy",  32'(busy),      32'd1);
    req_valid = '0;
    out_ready = 1'b0;

    // Reset while FULL clears everything before the next edge
    tick();
    chk("hold_data", 32'(out_data), 32'b1110);
    #2 rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_data",  32'(out_data),  32'd0);
    chk("midrst_busy",  32'(busy),      32'd0);
    #1 rst = 1'b0;

    // Round-robin with all four requesters valid
    req_valid = 4'b1111;
    req_data  = 16'h0F58;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("rr_gnt", 32'(req_ready), 32'(rr_gnt[i]));
      tick();
      chk("rr_valid", 32'(out_valid), 32'd1);
      chk("rr_data",  32'(out_data),  32'(rr_data[i]));
      chk("rr_id",    32'(out_id),    32'(rr_id[i]));
    end

    // Backpressure: three stalled cycles, then reload with no bubble
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_no_gnt", 32'(req_ready), 32'd0);
      chk("bp_data",   32'(out_data),  32'b1100);
      chk("bp_id",     32'(out_id),    32'd0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_gnt", 32'(req_ready), 32'b0010);
    tick();
    chk("bp_release_data", 32'(out_data), 32'b0111);
    chk("bp_release_id",   32'(out_id),   32'd1);

    // Drive rr_ptr to 3, then wrap to 0 and skip 1
    #1;
    chk("to_ptr3_gnt", 32'(req_ready), 32'b0100);
    tick();
    req_valid = 4'b0101;
    #1;
    chk("wrap_gnt", 32'(req_ready), 32'b0001);
    tick();
    chk("wrap_id",   32'(out_id),   32'd0);
    chk("wrap_data", 32'(out_data), 32'b1100);
    #1;
    chk("skip_gnt", 32'(req_ready), 32'b0100);
    tick();
    chk("skip_id",   32'(out_id),   32'd2);
    chk("skip_data", 32'(out_data), 32'b1000);
    req_valid = '0;
    tick();
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("drain_busy",  32'(busy),      32'd0);

`ifdef GRAY_DECODE_EN
    // Requester 1 word 1110 decoded and then encoded
    req_valid = 4'b0010;
    req_data  = 16'h00E0;
    req_dir   = 4'b0010;
    #1;
    chk("dec_gnt", 32'(req_ready), 32'b0010);
    tick();
    chk("dec_data", 32'(out_data), 32'b1011);
    chk("dec_dir",  32'(out_dir),  32'd1);
    chk("dec_id",   32'(out_id),   32'd1);
    req_dir = 4'b0000;
    tick();
    chk("enc_data", 32'(out_data), 32'b1001);
    chk("enc_dir",  32'(out_dir),  32'd0);
    req_valid = '0;
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_gray_conv_scheduler
`default_nettype wire
